// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the multi-cycle execute ALU.
//   alu_op_e : opcode encoding presented on the 4-bit op port; codes above
//              OP_MUL are illegal.
//   state_e  : control FSM states of alu_mc.
// Enum literals carry OP_/ST_ prefixes because MUL is both an opcode and a
// state name, and both enums share this package's scope.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_ANDN = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRL  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_BTR  = 4'd8,
        OP_MUL  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_comb.sv
// alu_comb: combinational single-cycle operations and their flags.
// Ports:
//   op      in   4      opcode (alu_op_e encoding)
//   a, b    in   WIDTH  operands; b[SHAMT_W-1:0] is the shift/rotate amount
//   res     out  WIDTH  result (0 for MUL and for illegal codes)
//   c       out  1      ADD carry-out / SUB no-borrow, else 0
//   v       out  1      signed overflow for ADD/SUB, else 0
//   illegal out  1      op is not an alu_op_e code
// MUL is legal here but produces 0; the iterative engine in alu_mc owns it.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             c,
    output logic             v,
    output logic             illegal
);

    logic [SHAMT_W-1:0]   sh;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   rol_t;
    logic [2*WIDTH-1:0]   ror_t;
    logic [WIDTH-1:0]     btr;

    assign sh    = b[SHAMT_W-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    // SUB is b - a; the extra top bit is the borrow.
    assign diff  = {1'b0, b} - {1'b0, a};
    // Rotates via a doubled copy of a: the wrapped bits fall into the kept half.
    assign rol_t = {a, a} << sh;
    assign ror_t = {a, a} >> sh;

    always_comb begin
        btr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            btr[i] = a[WIDTH-1-i];
        end
    end

    always_comb begin
        res     = '0;
        c       = 1'b0;
        v       = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c   = ~diff[WIDTH];
                v   = (b[WIDTH-1] != a[WIDTH-1]) && (diff[WIDTH-1] != b[WIDTH-1]);
            end
            OP_XOR:  res = a ^ b;
            OP_ANDN: res = a & ~b;
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_ROL:  res = rol_t[2*WIDTH-1:WIDTH];
            OP_ROR:  res = ror_t[WIDTH-1:0];
            OP_BTR:  res = btr;
            OP_MUL:  res = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute ALU between decode and writeback.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   operation handshake from decode
//   op, a_in, b_in       opcode and operands, sampled only on accept
//   out_valid, out_ready result handshake to writeback
//   result               registered result
//   flag_z/flag_c/flag_v registered flags, updated with result
//   illegal              registered: accepted op was not a legal code
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds valid and its payload stable until that edge, and
// ready may depend combinationally on the other side's ready (in_ready
// follows out_ready so a pop and a new accept can share one edge).
//
// Single-cycle ops write the result register on the accept edge. MUL runs a
// shift-add loop for WIDTH cycles in ST_MUL, then waits in ST_HOLD for the pop.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [WIDTH-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   result_nxt;
    logic               z_nxt, c_nxt, v_nxt, ill_nxt, ov_nxt;
    logic [WIDTH-1:0]   acc_step;

    logic [WIDTH-1:0]   comb_res;
    logic               comb_c, comb_v, comb_ill;
    logic               accept, pop;

    alu_comb #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_comb (
        .op      (op),
        .a       (a_in),
        .b       (b_in),
        .res     (comb_res),
        .c       (comb_c),
        .v       (comb_v),
        .illegal (comb_ill)
    );

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    // Only the low WIDTH bits of the product are kept, so the multiplicand can
    // shift out the top without widening the accumulator.
    assign acc_step = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            result    <= result_nxt;
            flag_z    <= z_nxt;
            flag_c    <= c_nxt;
            flag_v    <= v_nxt;
            illegal   <= ill_nxt;
            out_valid <= ov_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        result_nxt = result;
        z_nxt      = flag_z;
        c_nxt      = flag_c;
        v_nxt      = flag_v;
        ill_nxt    = illegal;
        ov_nxt     = out_valid;
        case (state)
            ST_IDLE: begin
                if (pop) ov_nxt = 1'b0;
                if (accept) begin
                    if (op == OP_MUL) begin
                        mcand_nxt  = a_in;
                        mplier_nxt = b_in;
                        acc_nxt    = '0;
                        cnt_nxt    = CNT_W'(WIDTH);
                        state_nxt  = ST_MUL;
                    end else begin
                        // A pop on this same edge is overridden: new result valid.
                        result_nxt = comb_res;
                        z_nxt      = (comb_res == '0);
                        c_nxt      = comb_c;
                        v_nxt      = comb_v;
                        ill_nxt    = comb_ill;
                        ov_nxt     = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    result_nxt = acc_step;
                    z_nxt      = (acc_step == '0);
                    c_nxt      = 1'b0;
                    v_nxt      = 1'b0;
                    ill_nxt    = 1'b0;
                    ov_nxt     = 1'b1;
                    state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    ov_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
